// File: rtl/lsu_pkg.sv
// Shared types and widths for the missile launch sequencer.
package lsu_pkg;

  localparam int unsigned DIST_W  = 14;
  localparam int unsigned PYLONS  = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_IGNITE = 3'd2,
    ST_FLIGHT = 3'd3,
    ST_IMPACT = 3'd4
  } lsu_state_e;

  // One-hot pylon advance, wrapping the top pylon back to pylon 0.
  function automatic logic [PYLONS-1:0] rotl_pylon(input logic [PYLONS-1:0] p);
    return {p[PYLONS-2:0], p[PYLONS-1]};
  endfunction

endpackage

// File: rtl/flight_range_counter.sv
// Range-to-target register: loads the launch distance, then closes by a fixed
// step per enabled cycle, clamping at zero and flagging completion.
module flight_range_counter
  import lsu_pkg::*;
#(
  parameter int unsigned SPEED_M_PER_CLK = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              dec,
  input  logic [DIST_W-1:0] load_val,
  output logic [DIST_W-1:0] range_remaining,
  output logic              done
);

  localparam logic [DIST_W-1:0] STEP = DIST_W'(SPEED_M_PER_CLK);

  logic [DIST_W-1:0] range_d, range_q;
  logic              done_d, done_q;

  // Compare before subtracting so the 14-bit difference never wraps.
  always_comb begin
    range_d = range_q;
    done_d  = done_q;
    if (load) begin
      range_d = load_val;
      done_d  = 1'b0;
    end else if (dec && !done_q) begin
      if (range_q <= STEP) begin
        range_d = '0;
        done_d  = 1'b1;
      end else begin
        range_d = range_q - STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_q <= '0;
      done_q  <= 1'b0;
    end else begin
      range_q <= range_d;
      done_q  <= done_d;
    end
  end

  assign range_remaining = range_q;
  assign done            = done_q;

endmodule

// File: rtl/missile_launch_sequencer.sv
// Launch sequencer: arms, ignites and tracks one missile at a time across four
// pylons, queueing requests that arrive while a sequence is in progress.
module missile_launch_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned ARM_CYCLES      = 4,
  parameter int unsigned SPEED_M_PER_CLK = 500,
  parameter int unsigned MAX_PENDING     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              launch_missile,
  input  logic [DIST_W-1:0] distance_to_target,
  input  logic              abort,
  output logic [PYLONS-1:0] pylon_select,
  output logic              ignition,
  output logic              missile_in_flight,
  output logic              impact,
  output logic [DIST_W-1:0] range_remaining,
  output logic [1:0]        pending_launches,
  output logic              queue_overflow,
  output logic [CNT_W-1:0]  flights_completed,
  output logic [STATE_W-1:0] LSU_state
);

  localparam int unsigned ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);
  localparam logic [1:0]       PEND_MAX = 2'(MAX_PENDING);

  lsu_state_e        state_d, state_q;
  logic [ARM_W-1:0]  arm_cnt_d, arm_cnt_q;
  logic [PYLONS-1:0] pylon_d, pylon_q;
  logic [1:0]        pending_d, pending_q;
  logic              ovf_d, ovf_q;
  logic [CNT_W-1:0]  flights_d, flights_q;
  logic              ignition_d, ignition_q;
  logic              flight_d, flight_q;
  logic              impact_d, impact_q;
  logic              rng_load, rng_dec, rng_done;

  flight_range_counter #(
    .SPEED_M_PER_CLK(SPEED_M_PER_CLK)
  ) u_range (
    .clk            (clk),
    .rst_n          (rst),
    .load           (rng_load),
    .dec            (rng_dec),
    .load_val       (distance_to_target),
    .range_remaining(range_remaining),
    .done           (rng_done)
  );

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    pylon_d   = pylon_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    flights_d = flights_q;
    rng_load  = 1'b0;
    rng_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (launch_missile && !abort) begin
          state_d = ST_ARM;
        end else if (!abort && pending_q != 2'd0) begin
          state_d   = ST_ARM;
          pending_d = pending_q - 2'd1;
        end
      end
      ST_ARM: begin
        if (abort)                       state_d = ST_IDLE;
        else if (arm_cnt_q == ARM_LAST)  state_d = ST_IGNITE;
        else                             arm_cnt_d = arm_cnt_q + ARM_W'(1);
      end
      // Range starts closing in IGNITE so the first FLIGHT cycle shows one step taken.
      ST_IGNITE: begin
        rng_dec = 1'b1;
        pylon_d = rotl_pylon(pylon_q);
        state_d = ST_FLIGHT;
      end
      ST_FLIGHT: begin
        rng_dec = 1'b1;
        if (rng_done) state_d = ST_IMPACT;
      end
      ST_IMPACT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE && state_d == ST_ARM) begin
      rng_load  = 1'b1;
      arm_cnt_d = '0;
    end

    // Requests outside IDLE queue up; a request coinciding with abort is lost.
    if (abort) begin
      pending_d = '0;
    end else if (launch_missile && state_q != ST_IDLE) begin
      if (pending_q == PEND_MAX) ovf_d = 1'b1;
      else                       pending_d = pending_q + 2'd1;
    end

    if (state_d == ST_IMPACT && flights_q != '1) flights_d = flights_q + CNT_W'(1);

    ignition_d = (state_d == ST_IGNITE);
    flight_d   = (state_d == ST_FLIGHT);
    impact_d   = (state_d == ST_IMPACT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      arm_cnt_q  <= '0;
      pylon_q    <= PYLONS'(1);
      pending_q  <= '0;
      ovf_q      <= 1'b0;
      flights_q  <= '0;
      ignition_q <= 1'b0;
      flight_q   <= 1'b0;
      impact_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      pylon_q    <= pylon_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      flights_q  <= flights_d;
      ignition_q <= ignition_d;
      flight_q   <= flight_d;
      impact_q   <= impact_d;
    end
  end

  assign pylon_select      = pylon_q;
  assign ignition          = ignition_q;
  assign missile_in_flight = flight_q;
  assign impact            = impact_q;
  assign pending_launches  = pending_q;
  assign queue_overflow    = ovf_q;
  assign flights_completed = flights_q;
  assign LSU_state         = state_q;

endmodule

// File: tb/tb_missile_launch_sequencer.sv
// Randomized bench for missile_launch_sequencer against a timeline model that
// derives each launch's phases from its start cycle and distance.
module tb_missile_launch_sequencer;

  localparam int ARM  = 4;
  localparam int SPD  = 500;
  localparam int MAXP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        launch_missile = 1'b0;
  logic [13:0] distance_to_target = '0;
  logic        abort = 1'b0;
  logic [3:0]  pylon_select;
  logic        ignition, missile_in_flight, impact, queue_overflow;
  logic [13:0] range_remaining;
  logic [1:0]  pending_launches;
  logic [7:0]  flights_completed;
  logic [2:0]  LSU_state;

  missile_launch_sequencer #(
    .ARM_CYCLES(ARM), .SPEED_M_PER_CLK(SPD), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .rst(rst), .launch_missile(launch_missile),
    .distance_to_target(distance_to_target), .abort(abort),
    .pylon_select(pylon_select), .ignition(ignition),
    .missile_in_flight(missile_in_flight), .impact(impact),
    .range_remaining(range_remaining), .pending_launches(pending_launches),
    .queue_overflow(queue_overflow), .flights_completed(flights_completed),
    .LSU_state(LSU_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Timeline model: a launch decided in cycle s occupies ARM for s+1..s+ARM,
  // ignites at s+ARM+1, flies n cycles, then reports impact.
  int m_active, m_start, m_dist, m_nfl, m_pyl, m_pend, m_ovf, m_flights, m_range;
  int e_phase, e_k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_pend = 0; m_ovf = 0; m_flights = 0; m_pyl = 0; m_range = 0;
    m_start = 0; m_dist = 0; m_nfl = 0;
  endtask

  task automatic compute_exp();
    int r;
    e_phase = 0;
    e_k = 0;
    if (m_active != 0) begin
      e_k = cyc - m_start;
      if (e_k <= ARM)                e_phase = 1;
      else if (e_k == ARM + 1)       e_phase = 2;
      else if (e_k <= ARM + 1 + m_nfl) e_phase = 3;
      else                           e_phase = 4;
      if (e_phase == 3) begin
        r = m_dist - (e_k - ARM - 1) * SPD;
        m_range = (r < 0) ? 0 : r;
      end else if (e_phase == 4) begin
        m_range = 0;
      end else begin
        m_range = m_dist;
      end
    end
  endtask

  task automatic check_outputs();
    check("state",    32'(LSU_state),         e_phase);
    check("pylon",    32'(pylon_select),      32'(1) << m_pyl);
    check("ignition", 32'(ignition),          32'(e_phase == 2));
    check("in_flight",32'(missile_in_flight), 32'(e_phase == 3));
    check("impact",   32'(impact),            32'(e_phase == 4));
    check("range",    32'(range_remaining),   m_range);
    check("pending",  32'(pending_launches),  m_pend);
    check("overflow", 32'(queue_overflow),    m_ovf);
    check("flights",  32'(flights_completed), m_flights);
  endtask

  task automatic start_seq(input int d);
    m_active = 1;
    m_start  = cyc;
    m_dist   = d;
    m_nfl    = (d == 0) ? 1 : (d + SPD - 1) / SPD;
  endtask

  task automatic model_update(input bit l, input bit a, input int d);
    if (e_phase == 0) begin
      if (a)              m_pend = 0;
      else if (l)         start_seq(d);
      else if (m_pend > 0) begin m_pend--; start_seq(d); end
    end else begin
      if (a)      m_pend = 0;
      else if (l) begin
        if (m_pend == MAXP) m_ovf = 1;
        else                m_pend++;
      end
      if (e_phase == 1 && a) m_active = 0;
      if (e_phase == 2)      m_pyl = (m_pyl + 1) % 4;
      if (e_phase == 3 && e_k == ARM + 1 + m_nfl && m_flights < 255) m_flights++;
      if (e_phase == 4)      m_active = 0;
    end
  endtask

  // One clock: check the state left by the last edge, then drive this cycle's inputs.
  task automatic step(input bit l, input bit a, input int d);
    @(negedge clk);
    compute_exp();
    check_outputs();
    launch_missile     = l;
    abort              = a;
    distance_to_target = 14'(d);
    model_update(l, a, d);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compute_exp();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // single launch at 2000 m
    step(1'b1, 1'b0, 2000);
    idle(14);
    check("first_flights", 32'(flights_completed), 32'd1);
    check("first_pylon",   32'(pylon_select),      32'b0010);

    // zero and sub-step distances
    step(1'b1, 1'b0, 0);
    idle(10);
    step(1'b1, 1'b0, 499);
    idle(10);

    // queue fills while the first sequence runs, fourth extra request overflows
    step(1'b1, 1'b0, 1200);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 700);
    step(1'b1, 1'b0, 300);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 900);
    idle(2);
    check("queue_ovf", 32'(queue_overflow), 32'd1);
    idle(70);

    // abort on the second ARM cycle
    step(1'b1, 1'b0, 2000);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    idle(6);
    // abort during flight is ignored by the missile
    step(1'b1, 1'b0, 3000);
    idle(7);
    step(1'b0, 1'b1, 0);
    idle(12);

    // asynchronous reset in the middle of a long flight
    step(1'b1, 1'b0, 5000);
    idle(8);
    @(negedge clk);
    launch_missile = 1'b0;
    abort = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    compute_exp();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    idle(20);
    check("reset_flights", 32'(flights_completed), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit l, a;
      int d;
      l = ($urandom_range(0, 5) == 0);
      a = ($urandom_range(0, 39) == 0);
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16383))
                                      : int'($urandom_range(0, 3000));
      step(l, a, d);
    end
    idle(60);

    // saturate the flight counter
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0, 0);
      idle(7);
    end
    idle(20);
    check("sat_flights", 32'(flights_completed), 32'd255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/missile_launch_sequencer.md
Name: missile_launch_sequencer

Overview:
- Downstream stage of the combat control unit; consumes its launch_missile pulse and 14-bit distance_to_target (metres).
- Sequences each launch on one of 4 pylons: arming delay, one-cycle ignition, time-of-flight countdown, impact report.
- Buffers launch requests that arrive while a sequence is busy in a small pending queue.

Parameters:
- ARM_CYCLES, 4, clocks spent in ARM before ignition (>=1).
- SPEED_M_PER_CLK, 500, metres closed per clock in FLIGHT (1..16383).
- MAX_PENDING, 3, depth of the pending-launch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- launch_missile  input  1  one-cycle launch request from the weapons control unit.
- distance_to_target  input  14  current target range in metres.
- abort  input  1  level; cancels arming and flushes the queue.
- pylon_select  output  4  one-hot pylon for the current or next launch.
- ignition  output  1  one-cycle motor ignition pulse.
- missile_in_flight  output  1  high while in FLIGHT.
- impact  output  1  one-cycle impact pulse.
- range_remaining  output  14  metres left to target for the current missile.
- pending_launches  output  2  queued requests.
- queue_overflow  output  1  sticky; set when a request is dropped.
- flights_completed  output  8  impacts counted, saturating at 255.
- LSU_state  output  3  current FSM state.

Behaviour:
- Reset (rst=0, asynchronous) forces all of the following; they hold until the first clk edge after rst returns high:
  - LSU_state=IDLE, pylon_select=4'b0001.
  - ignition=0, impact=0, missile_in_flight=0.
  - range_remaining=0, pending_launches=0, queue_overflow=0, flights_completed=0.
- A reset mid-flight abandons the missile; no impact is reported.
- States and encodings: IDLE=0, ARM=1, IGNITE=2, FLIGHT=3, IMPACT=4.
- IDLE:
  - launch_missile=1 -> ARM next cycle; the pending count is unchanged.
  - Otherwise, if pending>0 -> ARM and pending decrements.
  - If a queued launch starts and launch_missile=1 in the same cycle, pending is unchanged (decrement and increment cancel).
- Entering ARM:
  - range_remaining latches distance_to_target on the IDLE->ARM edge.
  - ARM lasts exactly ARM_CYCLES clocks, then -> IGNITE.
  - abort=1 in ARM -> IDLE next cycle; pending clears; pylon is not advanced; no ignition.
- IGNITE (1 cycle):
  - ignition=1.
  - pylon_select rotates left at exit (0001->0010->0100->1000->0001).
  - Always -> FLIGHT; abort is ignored here.
- FLIGHT:
  - missile_in_flight=1.
  - Each cycle: if range_remaining <= SPEED_M_PER_CLK, range_remaining becomes 0 and the FSM -> IMPACT. Otherwise range_remaining -= SPEED_M_PER_CLK.
  - Flight cycles = max(1, ceil(d/SPEED_M_PER_CLK)); a latched distance of 0 gives 1 cycle.
  - abort is ignored in FLIGHT (missile already away).
- IMPACT (1 cycle):
  - impact=1.
  - flights_completed increments, saturating at 255.
  - -> IDLE.
- Pending queue:
  - launch_missile=1 in any state other than IDLE increments pending.
  - At MAX_PENDING the request is dropped and queue_overflow is set; it clears only on reset.
  - abort in IDLE or ARM clears pending; abort in IGNITE/FLIGHT/IMPACT clears pending as well.
  - A launch_missile arriving together with abort is dropped.
- Outputs are registered. Latency from launch_missile at cycle t (in IDLE):
  - ARM over t+1..t+ARM_CYCLES.
  - ignition at t+ARM_CYCLES+1.
  - FLIGHT starts at t+ARM_CYCLES+2.
- Arithmetic: the subtraction is 14-bit unsigned; the compare-before-subtract guarantees no wrap.

Decomposition:
- Package lsu_pkg holds:
  - State encodings (3-bit).
  - DIST_W=14, PYLONS=4, CNT_W=8 constants.
- One natural sub-module, flight_range_counter, owns the range logic:
  - Latch-on-load, saturating decrement by SPEED_M_PER_CLK.
  - Outputs range_remaining and a done flag.
- FSM, pylon rotator and pending counter stay in the top module.

Test Plan:
- Reset then single launch, distance=2000, ARM_CYCLES=4, SPEED=500, launch at t:
  - ignition at t+5.
  - range_remaining 1500/1000/500/0 across t+6..t+9.
  - impact at t+10.
  - flights_completed=1, pylon_select=0010.
- Distance=0 and distance=499:
  - Exactly one FLIGHT cycle each, then impact.
  - range_remaining=0.
- Queueing:
  - Launch, then launch_missile pulses at t+2, t+3, t+4, t+6 during the first sequence.
  - pending reaches 3 and queue_overflow=1 after the 4th extra pulse.
  - Three further sequences run back-to-back with pylons 0010, 0100, 1000 at their ignitions; the next would use 0001.
- Abort:
  - abort=1 at ARM cycle 2 -> IDLE next cycle, no ignition, pylon stays 0001, pending=0.
  - abort during FLIGHT -> impact still occurs on schedule.
- Asynchronous reset mid-FLIGHT (rst low between clock edges):
  - All outputs go to reset values immediately.
  - No impact pulse; flights_completed stays at its reset value 0.
- Saturation: 256 complete flights -> flights_completed holds 255.
